metadata_lane_arbiter: RTL and testbench

Merges the per-frame metadata records of several parallel parser lanes onto one downstream metadata channel. Each lane's metadata packager emits a single-cycle `metadata_valid` pulse per frame and cannot be stalled. This block holds one record per lane, grants the shared output round-robin, and presents it with a valid/ready handshake. It sits between the lane packagers and the single classification/lookup consumer.

---
 rtl/eth_parser_pkg.sv | 25 ++
 rtl/metadata_lane_arbiter_rr_arbiter.sv | 32 +++
 rtl/metadata_lane_arbiter.sv | 102 ++++++++++
 tb/tb_metadata_lane_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_parser_pkg.sv
// Shared Ethernet parser types: the frame metadata record and the lane-tagged
// record used by the metadata lane arbiter.
package eth_parser_pkg;

    // Per-frame metadata record produced by a lane packager.
    typedef struct packed {
        logic [47:0] dest_mac;
        logic [47:0] src_mac;
        logic [15:0] ethertype;
        logic        vlan_valid;
        logic [11:0] vlan_id;
        logic [15:0] frame_len;
    } eth_metadata_t;

    localparam int unsigned MAX_META_LANES  = 8;
    localparam int unsigned META_DROP_CNT_W = 16;
    localparam int unsigned META_LANE_IDX_W = $clog2(MAX_META_LANES);

    // Metadata record tagged with its source lane.
    typedef struct packed {
        eth_metadata_t               meta;
        logic [META_LANE_IDX_W-1:0]  lane;
    } eth_meta_lane_t;

endpackage

// File: rtl/metadata_lane_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request after last_grant, wrapping.
module rr_arbiter #(
    parameter  int unsigned NUM_LANES = 4,
    localparam int unsigned LANE_W    = $clog2(NUM_LANES)
) (
    input  logic [NUM_LANES-1:0] req,
    input  logic [LANE_W-1:0]    last_grant,
    input  logic                 en,
    output logic [NUM_LANES-1:0] grant_c,
    output logic [LANE_W-1:0]    grant_idx_c,
    output logic                 any_grant_c
);

    logic [LANE_W-1:0] idx;

    // Scan lanes starting one past the previous winner; first hit wins.
    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        any_grant_c = 1'b0;
        idx         = '0;
        for (int k = 1; k <= int'(NUM_LANES); k++) begin
            idx = LANE_W'((32'(last_grant) + 32'(k)) % NUM_LANES);
            if (en && !any_grant_c && req[idx]) begin
                grant_c[idx] = 1'b1;
                grant_idx_c  = idx;
                any_grant_c  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/metadata_lane_arbiter.sv
// Merges single-cycle metadata records from parallel parser lanes onto one
// valid/ready output channel. One holding slot per lane, round-robin grant.
// Optional per-lane drop counters: define METADATA_ARB_STATS_EN.
module metadata_lane_arbiter
    import eth_parser_pkg::*;
#(
    parameter  int unsigned NUM_LANES = 4,
    localparam int unsigned LANE_W    = $clog2(NUM_LANES)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  eth_metadata_t [NUM_LANES-1:0]          in_metadata,
    input  logic [NUM_LANES-1:0]                   in_valid,
    output eth_metadata_t                          out_metadata,
    output logic [LANE_W-1:0]                      out_lane,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [NUM_LANES-1:0]                   drop_pulse
`ifdef METADATA_ARB_STATS_EN
    ,
    output logic [NUM_LANES-1:0][META_DROP_CNT_W-1:0] drop_count
`endif
);

    eth_metadata_t [NUM_LANES-1:0] slot_q;
    logic [NUM_LANES-1:0]          full_q;
    logic [LANE_W-1:0]             last_grant_q;
    eth_meta_lane_t                out_q;

    logic                          load_c;
    logic [NUM_LANES-1:0]          grant_c;
    logic [LANE_W-1:0]             grant_idx_c;
    logic                          any_grant_c;

    assign load_c       = !out_valid || out_ready;
    assign out_metadata = out_q.meta;
    assign out_lane     = LANE_W'(out_q.lane);

    rr_arbiter #(.NUM_LANES(NUM_LANES)) u_rr_arbiter (
        .req         (full_q),
        .last_grant  (last_grant_q),
        .en          (load_c),
        .grant_c     (grant_c),
        .grant_idx_c (grant_idx_c),
        .any_grant_c (any_grant_c)
    );

    // Lane slots: capture when empty or being drained this edge, else drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q     <= '0;
            full_q     <= '0;
            drop_pulse <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_LANES); i++) begin
                if (in_valid[i] && (!full_q[i] || grant_c[i])) begin
                    slot_q[i] <= in_metadata[i];
                    full_q[i] <= 1'b1;
                end else if (grant_c[i]) begin
                    full_q[i] <= 1'b0;
                end
            end
            drop_pulse <= in_valid & full_q & ~grant_c;
        end
    end

    // Output register and round-robin pointer; pointer moves only on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            out_valid    <= 1'b0;
            last_grant_q <= LANE_W'(NUM_LANES - 1);
        end else if (load_c) begin
            if (any_grant_c) begin
                out_q.meta   <= slot_q[grant_idx_c];
                out_q.lane   <= META_LANE_IDX_W'(grant_idx_c);
                out_valid    <= 1'b1;
                last_grant_q <= grant_idx_c;
            end else begin
                out_valid    <= 1'b0;
            end
        end
    end

`ifdef METADATA_ARB_STATS_EN
    // Saturating per-lane drop counters, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_LANES); i++) begin
                if (drop_pulse[i] && (drop_count[i] != '1)) begin
                    drop_count[i] <= drop_count[i] + META_DROP_CNT_W'(1);
                end
            end
        end
    end
`else
    // Statistics counters not built in this configuration.
`endif

endmodule

// File: tb/tb_metadata_lane_arbiter.sv
// Directed self-checking bench for metadata_lane_arbiter (NUM_LANES = 4).
module tb_metadata_lane_arbiter;
    import eth_parser_pkg::*;

    localparam int unsigned NL = 4;

    logic                       clk = 1'b0;
    logic                       rst_n;
    eth_metadata_t [NL-1:0]     in_metadata;
    logic [NL-1:0]              in_valid;
    eth_metadata_t              out_metadata;
    logic [1:0]                 out_lane;
    logic                       out_valid;
    logic                       out_ready;
    logic [NL-1:0]              drop_pulse;
`ifdef METADATA_ARB_STATS_EN
    logic [NL-1:0][15:0]        drop_count;
`endif

    int checks   = 0;
    int failures = 0;

    metadata_lane_arbiter #(.NUM_LANES(NL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_metadata  (in_metadata),
        .in_valid     (in_valid),
        .out_metadata (out_metadata),
        .out_lane     (out_lane),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .drop_pulse   (drop_pulse)
`ifdef METADATA_ARB_STATS_EN
        ,
        .drop_count   (drop_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic eth_metadata_t mk(input logic [7:0] s);
        eth_metadata_t m;
        m.dest_mac   = {6{s}};
        m.src_mac    = {6{~s}};
        m.ethertype  = {s, 8'h08};
        m.vlan_valid = s[0];
        m.vlan_id    = {4'hA, s};
        m.frame_len  = {8'h05, s};
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        in_valid    = '0;
        in_metadata = '0;
        out_ready   = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        in_valid = 4'b0001;
        in_metadata[0] = mk(8'h3C);
        tick();
        in_valid = '0;
        checks++;
        if (out_valid !== 1'b0 || out_lane !== 2'd0 || out_metadata !== '0 || drop_pulse !== '0) begin
            failures++;
            $display("FAIL reset_state: valid=%b lane=%0d meta=%h drop=%b required 0/0/0/0",
                     out_valid, out_lane, out_metadata, drop_pulse);
        end
`ifdef METADATA_ARB_STATS_EN
        checks++;
        if (drop_count !== '0) begin
            failures++;
            $display("FAIL reset_drop_count: got %h required 0", drop_count);
        end
`endif
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_ignores_in_valid: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_single_lane();
        eth_metadata_t rec;
        do_reset();
        rec = mk(8'h5A);
        rec.dest_mac = 48'h001122334455;
        in_metadata[2] = rec;
        in_valid = 4'b0100;
        tick();
        in_valid = '0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_latency1: out_valid=%b required 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_lane !== 2'd2 || out_metadata !== rec) begin
            failures++;
            $display("FAIL single_out: valid=%b lane=%0d meta=%h required 1/2/%h",
                     out_valid, out_lane, out_metadata, rec);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_after: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_all_lanes();
        eth_metadata_t recs [NL];
        do_reset();
        for (int i = 0; i < int'(NL); i++) begin
            recs[i] = mk(8'(8'h10 + i));
            in_metadata[i] = recs[i];
        end
        in_valid = 4'b1111;
        tick();
        in_valid = '0;
        tick();
        for (int k = 0; k < int'(NL); k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_lane !== 2'(k) || out_metadata !== recs[k] || drop_pulse !== '0) begin
                failures++;
                $display("FAIL all_lanes_%0d: valid=%b lane=%0d drop=%b meta=%h required 1/%0d/0000/%h",
                         k, out_valid, out_lane, drop_pulse, out_metadata, k, recs[k]);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL all_lanes_drain: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_rotation();
        do_reset();
        in_metadata[1] = mk(8'h21);
        in_valid = 4'b0010;
        tick();
        in_valid = '0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_lane !== 2'd1) begin
            failures++;
            $display("FAIL rot_first: valid=%b lane=%0d required 1/1", out_valid, out_lane);
        end
        in_metadata[0] = mk(8'h30);
        in_metadata[3] = mk(8'h33);
        in_valid = 4'b1001;
        tick();
        in_valid = '0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_lane !== 2'd3 || out_metadata !== mk(8'h33)) begin
            failures++;
            $display("FAIL rot_lane3: valid=%b lane=%0d required 1/3", out_valid, out_lane);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_lane !== 2'd0 || out_metadata !== mk(8'h30)) begin
            failures++;
            $display("FAIL rot_lane0: valid=%b lane=%0d required 1/0", out_valid, out_lane);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        in_metadata[0] = mk(8'hA0);
        in_valid = 4'b0001;
        tick();
        in_valid = '0;
        tick();
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_lane !== 2'd0 || out_metadata !== mk(8'hA0)) begin
                failures++;
                $display("FAIL bp_hold_%0d: valid=%b lane=%0d meta=%h required 1/0/%h",
                         c, out_valid, out_lane, out_metadata, mk(8'hA0));
            end
            tick();
        end
        in_metadata[0] = mk(8'hB0);
        in_valid = 4'b0001;
        tick();
        checks++;
        if (drop_pulse !== 4'b0000) begin
            failures++;
            $display("FAIL bp_fill: drop_pulse=%b required 0000", drop_pulse);
        end
        in_metadata[0] = mk(8'hC0);
        tick();
        in_valid = '0;
        checks++;
        if (drop_pulse !== 4'b0001) begin
            failures++;
            $display("FAIL bp_drop: drop_pulse=%b required 0001", drop_pulse);
        end
        tick();
        checks++;
        if (drop_pulse !== 4'b0000 || out_valid !== 1'b1 || out_metadata !== mk(8'hA0)) begin
            failures++;
            $display("FAIL bp_after_drop: drop=%b valid=%b meta=%h required 0000/1/%h",
                     drop_pulse, out_valid, out_metadata, mk(8'hA0));
        end
`ifdef METADATA_ARB_STATS_EN
        checks++;
        if (drop_count[0] !== 16'd1 || drop_count[1] !== 16'd0) begin
            failures++;
            $display("FAIL bp_drop_count: got %0d/%0d required 1/0", drop_count[0], drop_count[1]);
        end
`endif
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_lane !== 2'd0 || out_metadata !== mk(8'hB0)) begin
            failures++;
            $display("FAIL bp_release: valid=%b meta=%h required 1/%h", out_valid, out_metadata, mk(8'hB0));
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_empty: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_same_edge_refill();
        do_reset();
        in_metadata[1] = mk(8'h41);
        in_valid = 4'b0010;
        tick();
        in_metadata[1] = mk(8'h42);
        tick();
        in_valid = '0;
        checks++;
        if (out_valid !== 1'b1 || out_lane !== 2'd1 || out_metadata !== mk(8'h41) || drop_pulse !== '0) begin
            failures++;
            $display("FAIL refill_first: valid=%b lane=%0d drop=%b meta=%h required 1/1/0000/%h",
                     out_valid, out_lane, drop_pulse, out_metadata, mk(8'h41));
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_lane !== 2'd1 || out_metadata !== mk(8'h42) || drop_pulse !== '0) begin
            failures++;
            $display("FAIL refill_second: valid=%b lane=%0d drop=%b meta=%h required 1/1/0000/%h",
                     out_valid, out_lane, drop_pulse, out_metadata, mk(8'h42));
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL refill_drain: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < int'(NL); i++) in_metadata[i] = mk(8'(8'h60 + i));
        in_valid = 4'b1111;
        tick();
        in_valid = '0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_lane !== 2'd0) begin
            failures++;
            $display("FAIL mid_setup: valid=%b lane=%0d required 1/0", out_valid, out_lane);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_lane !== 2'd0 || out_metadata !== '0 || drop_pulse !== '0) begin
            failures++;
            $display("FAIL mid_async_clear: valid=%b lane=%0d meta=%h required 0/0/0",
                     out_valid, out_lane, out_metadata);
        end
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL mid_stale_%0d: out_valid=%b required 0", c, out_valid);
            end
        end
        in_metadata[1] = mk(8'h71);
        in_metadata[3] = mk(8'h73);
        in_valid = 4'b1010;
        tick();
        in_valid = '0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_lane !== 2'd1 || out_metadata !== mk(8'h71)) begin
            failures++;
            $display("FAIL mid_priority: valid=%b lane=%0d required 1/1", out_valid, out_lane);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = '0;
        in_metadata = '0;
        out_ready   = 1'b1;
        test_reset();
        test_single_lane();
        test_all_lanes();
        test_rotation();
        test_backpressure();
        test_same_edge_refill();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
